// File: rtl/mfe_host_ctrl.sv
// Host-side controller for the median filter engine: loads a frame into the
// grayscale image memory, hands it to the engine and streams the result back out.
module mfe_host_ctrl #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [AW-1:0] img_addr,
  output logic [DW-1:0] img_wdata,
  output logic          img_wen,
  output logic          ready,
  input  logic          busy,
  output logic [AW-1:0] res_addr,
  input  logic [DW-1:0] res_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(IMG_W * IMG_H - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_REQ,
    S_RUN,
    S_RD_REQ,
    S_RD_CAP,
    S_OUT
  } state_t;

  state_t        state;
  logic [AW-1:0] idx;

  // NOTE: every register, outputs included, lives in this one clocked block and
  // is assigned with <= so all of them update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_LOAD;
      idx       <= '0;
      in_ready  <= 1'b0;
      img_addr  <= '0;
      img_wdata <= '0;
      img_wen   <= 1'b0;
      ready     <= 1'b0;
      res_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      img_wen <= 1'b0;
      done    <= 1'b0;

      case (state)
        S_LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            img_wen   <= 1'b1;
            img_addr  <= idx;
            img_wdata <= in_data;
            if (idx == LAST_IDX) begin
              idx      <= '0;
              in_ready <= 1'b0;
              state    <= S_REQ;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        // ready must be seen high before busy can release it
        S_REQ: begin
          if (!ready) begin
            ready <= 1'b1;
          end else if (busy) begin
            ready <= 1'b0;
            state <= S_RUN;
          end
        end

        S_RUN: begin
          if (!busy) begin
            res_addr <= idx;
            state    <= S_RD_REQ;
          end
        end

        // res_addr is already presented on entry, so the one-cycle read
        // latency is absorbed here and res_rdata is valid in S_RD_CAP
        S_RD_REQ: begin
          res_addr <= idx;
          state    <= S_RD_CAP;
        end

        S_RD_CAP: begin
          out_data  <= res_rdata;
          out_valid <= 1'b1;
          out_last  <= (idx == LAST_IDX);
          state     <= S_OUT;
        end

        S_OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              idx      <= '0;
              done     <= 1'b1;
              in_ready <= 1'b1;
              state    <= S_LOAD;
            end else begin
              idx      <= idx + 1'b1;
              res_addr <= idx + 1'b1;
              state    <= S_RD_REQ;
            end
          end
        end

        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mfe_host_ctrl.sv
// Scoreboard bench for mfe_host_ctrl: frame writes and readback beats are
// queued when issued and popped by an independent negedge monitor.
module tb_mfe_host_ctrl;
  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int NPIX  = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] img_addr;
  logic [DW-1:0] img_wdata;
  logic          img_wen;
  logic          ready, busy;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_rdata = '0;
  logic          out_valid, out_last, out_ready, done;
  logic [DW-1:0] out_data;

  mfe_host_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .img_addr(img_addr), .img_wdata(img_wdata), .img_wen(img_wen),
    .ready(ready), .busy(busy),
    .res_addr(res_addr), .res_rdata(res_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;

  // Result memory: one-cycle read latency, contents ~address[7:0]
  always @(posedge clk) res_rdata <= ~res_addr[7:0];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  wr_t   wr_q[$];
  beat_t rd_q[$];
  int    load_cnt = 0;

  // Stimulus side: each accepted input pixel queues the write it must cause.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q.delete();
      load_cnt = 0;
    end else if (in_valid && in_ready) begin
      wr_q.push_back('{addr: AW'(load_cnt), data: in_data});
      load_cnt = (load_cnt + 1) % NPIX;
    end
  end

  // Monitor
  int            wen_cnt = 0, done_cnt = 0, beats = 0, hold_cnt = 0;
  logic          last_wr_pending = 1'b0, last_rd_pending = 1'b0, prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [AW-1:0] prev_raddr;
  wr_t           we;
  beat_t         be;

  always @(negedge clk) begin
    if (reset) begin
      wen_cnt         = 0;
      last_wr_pending = 1'b0;
      last_rd_pending = 1'b0;
      prev_hold       = 1'b0;
    end else begin
      if (last_wr_pending) begin
        check("ready_after_last_write", ready, 1);
        last_wr_pending = 1'b0;
      end
      if (img_wen) begin
        wen_cnt++;
        if (wr_q.size() == 0) begin
          check("unexpected_img_wen", 1, 0);
        end else begin
          we = wr_q.pop_front();
          check("img_addr", img_addr, we.addr);
          check("img_wdata", img_wdata, we.data);
          if (we.addr == AW'(NPIX - 1)) begin
            check("ready_low_during_last_write", ready, 0);
            last_wr_pending = 1'b1;
          end
        end
      end

      if (last_rd_pending) begin
        check("done_pulse", done, 1);
        check("in_ready_after_done", in_ready, 1);
        last_rd_pending = 1'b0;
      end
      if (done) done_cnt++;

      if (prev_hold) begin
        hold_cnt++;
        check("hold_out_valid", out_valid, 1);
        check("hold_out_data", out_data, prev_data);
        check("hold_out_last", out_last, prev_last);
        check("hold_res_addr", res_addr, prev_raddr);
      end
      if (out_valid) begin
        if (rd_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else if (out_ready) begin
          be = rd_q.pop_front();
          check("out_data", out_data, be.data);
          check("out_last", out_last, be.last);
          beats++;
          if (be.last) last_rd_pending = 1'b1;
        end
      end
      prev_hold  = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_raddr = res_addr;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check_all_zero(input string name);
    check(name, {in_ready, img_wen, img_addr, img_wdata, ready, res_addr,
                 out_valid, out_data, out_last, done}, 0);
  endtask

  initial begin
    int            sent, guard, lat;
    logic [DW-1:0] kb;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    busy      = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #1 reset = 1'b0;

    // Partial load with random gaps, then reset mid-frame
    sent = 0; guard = 0;
    while (sent < 100 && guard < 1000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      guard++;
    end
    check("partial_load_count", sent, 100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_load_reset_outputs");
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);

    // Full frame load: pixel value = idx mod 256, in_valid held high
    sent = 0; guard = 0;
    while (sent < NPIX && guard < NPIX + 100) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = DW'(sent);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      guard++;
    end
    check("full_load_count", sent, NPIX);
    @(posedge clk); #1;
    in_data   = DW'($urandom_range(0, 255));
    out_ready = 1'b0;

    // Engine handshake; in_valid stays high as stray input throughout
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_rise", ready, 1);
    check("wen_count_full_frame", wen_cnt, NPIX);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("ready_held_busy_low", ready, 1);
    end
    @(posedge clk); #1 busy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_drop_on_busy", ready, 0);
    for (int i = 0; i < 49; i++) begin
      @(negedge clk);
      check("stray_in_ready", in_ready, 0);
      check("stray_img_wen", img_wen, 0);
      check("stray_ready", ready, 0);
    end

    // Engine finished: the filtered frame is the result memory contents
    @(posedge clk); #1;
    for (int k = 0; k < NPIX; k++) begin
      kb = k[7:0];
      rd_q.push_back('{data: ~kb, last: (k == NPIX - 1)});
    end
    busy      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("first_beat_latency", lat, 4);

    // Backpressure on beat 5
    guard = 0;
    while (beats < 5 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #1 out_ready = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    check("beat5_presented", out_valid, 1);
    repeat (6) @(posedge clk);
    #1 out_ready = 1'b1;

    guard = 0;
    while (done_cnt == 0 && guard < 3 * NPIX + 200) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    @(negedge clk);
    check("readback_beats", beats, NPIX);
    check("readback_queue_empty", rd_q.size(), 0);
    check("bp_hold_cycles", (hold_cnt >= 6), 1);
    check("back_in_load", in_ready, 1);

    // out_ready toggling in S_LOAD must not produce output
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("no_out_valid_in_load", out_valid, 0);
    end
    check("done_count", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mfe_host_ctrl.md
Name: mfe_host_ctrl

Overview:
- Host-side controller for the median filter engine: the other end of the engine's ready/busy handshake and of both image memories.
- Accepts a 128x128 8-bit grayscale frame as a valid/ready stream and writes it into the Grayscale Image MEM.
- Raises ready to the filter engine, then tracks busy until the engine finishes.
- Reads the Result MEM back and emits the filtered frame as a valid/ready stream with an end-of-frame marker.

Parameters:
IMG_W, 128, pixels per row
IMG_H, 128, rows per frame
AW, 14, memory address width; log2(IMG_W*IMG_H)
DW, 8, pixel width

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input pixel valid
in_data  input  DW  input pixel, raster order (row-major, column fastest)
in_ready  output  1  controller can accept an input pixel
img_addr  output  AW  Grayscale Image MEM write address
img_wdata  output  DW  Grayscale Image MEM write data
img_wen  output  1  Grayscale Image MEM write enable
ready  output  1  frame loaded; request to the filter engine
busy  input  1  filter engine busy
res_addr  output  AW  Result MEM read address
res_rdata  input  DW  Result MEM read data; valid one cycle after res_addr
out_valid  output  1  output pixel valid
out_data  output  DW  output pixel
out_last  output  1  marks the final pixel of the frame; qualified by out_valid
out_ready  input  1  downstream accepts the output pixel
done  output  1  one-cycle pulse after the last output pixel is accepted

Behaviour:
- Address rule: address = row*IMG_W + col, held in a single AW-bit counter `idx`. Raster order throughout.
- Reset values: every output is 0; state = S_LOAD; idx = 0.
- Reset asserted in any state aborts immediately to these values. A partially loaded or partially read frame is discarded.

S_LOAD:
- in_ready = 1.
- On in_valid & in_ready: img_wen = 1, img_addr = idx, img_wdata = in_data, registered (write visible on the next cycle), then idx increments.
- img_wen is 0 in every cycle without a handshake.
- When the handshake occurs at idx = IMG_W*IMG_H-1: idx wraps to 0 and the state goes to S_REQ.
- in_ready = 0 in every state other than S_LOAD.

S_REQ:
- ready = 1, held until busy is sampled high; then ready = 0 and go to S_RUN.
- ready never deasserts while busy is low.

S_RUN:
- Wait for busy to be sampled low, then go to S_RD_REQ.
- A busy glitch low for a single cycle is treated as completion.

S_RD_REQ:
- res_addr = idx; go to S_RD_CAP.

S_RD_CAP:
- Register out_data = res_rdata.
- out_valid = 1.
- out_last = 1 if idx = IMG_W*IMG_H-1.
- Go to S_OUT.

S_OUT:
- Hold out_valid, out_data and out_last stable until out_ready.
- On out_valid & out_ready: out_valid = 0 and out_last = 0 on the next cycle.
  - If this was the last pixel: idx = 0, done = 1 for one cycle, return to S_LOAD.
  - Otherwise: idx increments and go to S_RD_REQ.

Timing and boundary rules:
- Readback throughput is 1 pixel per 3 cycles at most.
- Load accepts 1 pixel per cycle.
- out_ready asserted before out_valid has no effect.
- in_valid outside S_LOAD is ignored, with no write.
- busy high while in S_LOAD or during readback is ignored.
- idx is exactly AW bits. The frame-end compare is against IMG_W*IMG_H-1; no overflow path.

Test Plan:
1. Reset mid-load: stream 100 pixels, assert reset for 2 cycles. Required: all outputs 0, in_ready=1 after release. The next pixel is written to img_addr 0.
2. Full load: stream pixel value (idx mod 256) with in_valid held high for 16384 cycles. Required: 16384 img_wen pulses; img_addr 0..16383 in order; img_wdata matches; ready rises the cycle after the final write.
3. Handshake: hold busy low 10 cycles after ready rises; then busy high 50 cycles; then low. Required: ready stays 1 until busy is sampled high, then drops. Readback begins with res_addr=0 two cycles after busy falls.
4. Readback with a result memory model (1-cycle latency, contents = ~address[7:0]) and out_ready always 1. Required: 16384 beats, out_data sequence 0xFF, 0xFE, ...; out_last only on beat 16383; done pulses once; state returns to S_LOAD.
5. Backpressure: out_ready=0 for 7 cycles on beat 5. Required: out_data and out_valid stay stable; no res_addr advance; beat 6 follows after acceptance.
6. Stray inputs: in_valid=1 during S_RUN, and out_ready toggling during S_LOAD. Required: no img_wen and no out_valid.
